mat_loader: RTL

//  Upstream operand stage for matadd.
//  - Accepts a serial stream of 32-bit elements over a valid/ready handshake.
//  - Assembles operand A then operand B, each a row-major rsize x csize matrix.
//  - Presents both as packed in1/in2 buses and raises en.
//  - Waits for matadd done, with a timeout, then re-arms for the next pair.

---
 rtl/mat_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mat_loader.sv
// mat_loader: serial operand loader in front of matadd.
// Collects a row-major rsize x csize matrix A, then B, from a valid/ready
// stream, drives them onto packed in1/in2 buses, raises en and waits for
// mat_done (bounded by RUN_MAX) before re-arming for the next pair.
// Element [row][col] occupies bits [(row*csize+col)*32 +: 32].
// Optional feature macro: MAT_LOADER_LAST_CHECK_EN (s_last framing check
// driving the sticky err output; when undefined s_last is ignored, err=0).
module mat_loader #(
    parameter int rsize   = 2,
    parameter int csize   = 3,
    parameter int RUN_MIN = 2,
    parameter int RUN_MAX = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [31:0]                  s_data,
    input  logic                         s_last,
    output logic [rsize*csize*32-1:0]    in1,
    output logic [rsize*csize*32-1:0]    in2,
    output logic                         en,
    input  logic                         mat_done,
    output logic                         run_ok,
    output logic                         run_timeout,
    output logic                         err
);

    localparam int NW  = rsize * csize * 32;
    localparam int RW  = (rsize > 1) ? $clog2(rsize) : 1;
    localparam int CW  = (csize > 1) ? $clog2(csize) : 1;
    localparam int RCW = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;
    localparam int OW  = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [RW-1:0]  ROW_LAST = RW'(rsize - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(csize - 1);
    localparam logic [RCW-1:0] RC_LAST  = RCW'(RUN_MAX - 1);
    localparam logic [RCW-1:0] RC_MIN   = RCW'(RUN_MIN);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RCW-1:0]   rc_q, rc_d;
    logic [NW-1:0]    in1_q, in1_d;
    logic [NW-1:0]    in2_q, in2_d;
    logic             s_ready_q, s_ready_d;
    logic             en_q, en_d;
    logic             err_q, err_d;

    logic             beat_s;
    logic             frame_end_s;
    logic             done_s;
    logic             tmo_s;
    logic [OW-1:0]    off_s;

    assign beat_s      = s_valid && s_ready_q;
    assign frame_end_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // mat_done only counts once the matadd pipeline has had RUN_MIN cycles.
    assign done_s      = (state_q == ST_RUN) && (rc_q >= RC_MIN) && mat_done;
    // A completion in the last allowed cycle takes priority over the timeout.
    assign tmo_s       = (state_q == ST_RUN) && !done_s && (rc_q == RC_LAST);
    assign off_s       = OW'((32'(row_q) * 32'(csize) + 32'(col_q)) << 5);

`ifndef MAT_LOADER_LAST_CHECK_EN
    logic unused_s;
    assign unused_s = s_last;
`endif

    // Next-state, load counters, operand writes and the frame-error flag.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rc_d    = rc_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        err_d   = err_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (beat_s) begin
                    if (state_q == ST_LOAD_A) begin
                        in1_d[off_s +: 32] = s_data;
                    end else begin
                        in2_d[off_s +: 32] = s_data;
                    end
                    if (frame_end_s) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_RUN;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (done_s || tmo_s) begin
                    rc_d    = '0;
                    state_d = ST_LOAD_A;
                end else begin
                    rc_d = rc_q + RCW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
`ifdef MAT_LOADER_LAST_CHECK_EN
        if (beat_s && (s_last != ((state_q == ST_LOAD_B) && frame_end_s))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
`else
        err_d = 1'b0;
`endif
    end

    // Registered handshake and enable follow the upcoming state.
    always_comb begin
        s_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        en_d      = (state_d == ST_RUN);
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            row_q     <= '0;
            col_q     <= '0;
            rc_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            s_ready_q <= 1'b0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rc_q      <= rc_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            s_ready_q <= s_ready_d;
            en_q      <= en_d;
            err_q     <= err_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign in1         = in1_q;
    assign in2         = in2_q;
    assign en          = en_q;
    assign err         = err_q;
    assign run_ok      = done_s;
    assign run_timeout = tmo_s;

endmodule
